// File: rtl/soc_ahb3_sram_slave.sv
// AHB3-Lite slave front-end for a single-port SRAM (soc_sram_sp).
// Define SOC_AHB3_SRAM_ERR_EN to enable range/size/alignment ERROR responses.
module soc_ahb3_sram_slave #(
   parameter int PLEN          = 32,
   parameter int XLEN          = 32,
   parameter int MEM_SIZE_BYTE = 'h4000,
   parameter int WORD_AW       = PLEN-2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               HSEL,
   input  logic [PLEN-1:0]    HADDR,
   input  logic [XLEN-1:0]    HWDATA,
   output logic [XLEN-1:0]    HRDATA,
   input  logic               HWRITE,
   input  logic [2:0]         HSIZE,
   input  logic [2:0]         HBURST,
   input  logic [3:0]         HPROT,
   input  logic [1:0]         HTRANS,
   input  logic               HREADY,
   output logic               HREADYOUT,
   output logic               HRESP,
   output logic               sram_ce,
   output logic               sram_we,
   output logic               sram_oe,
   output logic [WORD_AW-1:0] sram_waddr,
   output logic [XLEN-1:0]    sram_din,
   output logic [3:0]         sram_sel,
   input  logic [XLEN-1:0]    sram_dout
);

   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RSTALL, S_RDATA, S_ERR1, S_ERR2} state_t;

   typedef struct packed {
      logic [WORD_AW-1:0] addr;
      logic [3:0]         sel;
   } req_t;

   state_t             state, state_nxt;
   req_t               req;
   logic [XLEN-1:0]    hrdata_q;
   logic               accept, err, rd_now;
   logic [PLEN-3:0]    haddr_word;
   logic [WORD_AW-1:0] waddr_a;
   logic [3:0]         sel_a;
   logic               unused_ok;

   assign accept     = HSEL & HREADY & HTRANS[1];
   assign haddr_word = HADDR[PLEN-1:2];
   assign waddr_a    = haddr_word[WORD_AW-1:0];
   assign unused_ok  = ^{HBURST, HPROT, HTRANS[0], haddr_word};

   always_comb begin
      case (HSIZE)
         3'd0:    sel_a = 4'b0001 << HADDR[1:0];
         3'd1:    sel_a = 4'b0011 << {HADDR[1], 1'b0};
         default: sel_a = 4'b1111;
      endcase
   end

`ifdef SOC_AHB3_SRAM_ERR_EN
   assign err = accept & ((HADDR >= PLEN'(MEM_SIZE_BYTE)) | (HSIZE > 3'd2) |
                          ((HSIZE == 3'd1) & HADDR[0]) |
                          ((HSIZE == 3'd2) & (|HADDR[1:0])));
`else
   assign err = 1'b0;
`endif

   // A read can only use the port right away when no write data phase owns it.
   assign rd_now = accept & ~err & ~HWRITE & (state != S_WDATA) & (state != S_RSTALL);

   always_comb begin
      state_nxt = S_IDLE;
      if (accept)
         state_nxt = err ? S_ERR1 : (HWRITE ? S_WDATA : S_RDATA);
      case (state)
         S_WDATA:  if (accept & ~err & ~HWRITE) state_nxt = S_RSTALL;
         S_RSTALL: state_nxt = S_RDATA;
         S_ERR1:   state_nxt = S_ERR2;
         default:  ;
      endcase

      HREADYOUT  = (state != S_RSTALL) & (state != S_ERR1);
      HRESP      = 1'b0;
`ifdef SOC_AHB3_SRAM_ERR_EN
      HRESP      = (state == S_ERR1) | (state == S_ERR2);
`endif
      HRDATA     = (state == S_RDATA) ? sram_dout : hrdata_q;
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_oe    = 1'b0;
      sram_waddr = req.addr;
      sram_sel   = 4'b0000;
      sram_din   = HWDATA;
      case (state)
         S_WDATA:  begin sram_ce = 1'b1; sram_we = 1'b1; sram_sel = req.sel; end
         S_RSTALL: begin sram_ce = 1'b1; sram_oe = 1'b1; sram_sel = req.sel; end
         default:  ;
      endcase
      if (rd_now) begin
         sram_ce    = 1'b1;
         sram_oe    = 1'b1;
         sram_waddr = waddr_a;
         sram_sel   = sel_a;
      end
      // Reset cancels whatever access was in flight this cycle.
      if (rst) begin
         sram_ce   = 1'b0;
         sram_we   = 1'b0;
         sram_oe   = 1'b0;
         sram_sel  = 4'b0000;
         HREADYOUT = 1'b1;
         HRESP     = 1'b0;
         HRDATA    = hrdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         req      <= '0;
         hrdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            req <= '{addr: waddr_a, sel: sel_a};
         if (state == S_RDATA)
            hrdata_q <= sram_dout;
      end
   end

endmodule
